// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester alu arbiter: fn codes, CC layout, FSM encoding.
package alu_arbiter_pkg;

  localparam int ALU_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fn_e;

  // Condition-code bit positions within {ZF,SF,OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET_VAL = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// 64-bit alu: add, sub (a-b), and, xor. Overflow is the signed-overflow flag, 0 for logic ops.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [1:0]       fn,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             ovf
);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (fn)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: requester ptr wins if valid, otherwise the other one.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       idx,
  output logic       any
);

  always_comb begin
    grant = 2'b00;
    any   = |valid;
    idx   = valid[ptr] ? ptr : ~ptr;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between two requesters with round-robin grant, a registered response
// and a condition-code register updated by set_cc requests.
//
//   state | meaning
//   IDLE  | no response held; grant on any valid request
//   RESP  | response held for owner; regrant same cycle when owner consumes it
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int         DATA_W   = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req0_fn,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_set_cc,
  input  logic [1:0]        req1_fn,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_set_cc,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf,
  output logic [2:0]        cc
);

  arb_state_e        state, state_nxt;
  logic              rr_ptr;
  logic              owner;
  logic [1:0]        grant;
  logic              gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic [1:0]        op_fn;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_set_cc;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic [2:0]        cc_nxt;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Operands go straight from the granted requester into the alu; no operand registers.
  always_comb begin
    op_fn     = gnt_idx ? req1_fn     : req0_fn;
    op_a      = gnt_idx ? req1_a      : req0_a;
    op_b      = gnt_idx ? req1_b      : req0_b;
    op_set_cc = gnt_idx ? req1_set_cc : req0_set_cc;
  end

  alu u_alu (
    .fn     (op_fn),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          accept    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner]) begin
          if (gnt_any) accept = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_ready = (accept && !reset) ? grant : 2'b00;
  end

  always_comb begin
    cc_nxt        = cc;
    cc_nxt[CC_ZF] = (alu_res == '0);
    cc_nxt[CC_SF] = alu_res[DATA_W-1];
    cc_nxt[CC_OF] = alu_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      cc         <= CC_RESET;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= gnt_idx;
        rr_ptr     <= ~gnt_idx;
        rsp_valid  <= grant;
        rsp_result <= alu_res;
        rsp_ovf    <= alu_ovf;
        if (op_set_cc) cc <= cc_nxt;
      end else if (state == RESP && rsp_ready[owner]) begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a transaction-level model predicts grants,
// results and condition codes; a monitor compares every presented response.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_fn, req1_fn;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_set_cc, req1_set_cc;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_ovf;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        g;
    logic [63:0] res;
    logic        ovf;
    logic [2:0]  cc;
  } item_t;

  item_t sb[$];

  logic       m_inflight;
  logic       m_owner;
  logic       m_rr;
  logic [2:0] m_cc;
  logic [1:0] seen_ready;

  alu_arbiter #(.DATA_W(64), .CC_RESET(3'b100)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_fn     (req0_fn),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_set_cc (req0_set_cc),
    .req1_fn     (req1_fn),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_set_cc (req1_set_cc),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_ovf     (rsp_ovf),
    .cc          (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alu from plain signed arithmetic on a 65-bit sum.
  task automatic ref_alu(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic o);
    logic signed [64:0] wide;
    wide = '0;
    o = 1'b0;
    case (fn)
      2'd0: wide = $signed({a[63], a}) + $signed({b[63], b});
      2'd1: wide = $signed({b[63], b});
      default: wide = '0;
    endcase
    if (fn == 2'd1) wide = $signed({a[63], a}) - wide;
    case (fn)
      2'd0, 2'd1: begin r = wide[63:0]; o = (wide[64] != wide[63]); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
  endtask

  // Cycle-level transaction model, evaluated on the falling edge with stable inputs.
  task automatic model_step();
    logic        can, g;
    logic [1:0]  exp_ready;
    logic [1:0]  fn;
    logic [63:0] a, b, r;
    logic        o, sc;
    item_t       it;
    seen_ready = req_ready;
    if (reset) begin
      check("req_ready_in_reset", 64'(req_ready), 64'(2'b00));
      sb.delete();
      m_inflight = 1'b0;
      m_owner    = 1'b0;
      m_rr       = 1'b0;
      m_cc       = 3'b100;
      return;
    end
    check("cc_track", 64'(cc), 64'(m_cc));
    can = !m_inflight || rsp_ready[m_owner];
    if (m_inflight && rsp_ready[m_owner]) m_inflight = 1'b0;
    exp_ready = 2'b00;
    g = 1'b0;
    if (can && req_valid != 2'b00) begin
      g = req_valid[m_rr] ? m_rr : !m_rr;
      exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (exp_ready != 2'b00) begin
      fn = g ? req1_fn : req0_fn;
      a  = g ? req1_a  : req0_a;
      b  = g ? req1_b  : req0_b;
      sc = g ? req1_set_cc : req0_set_cc;
      ref_alu(fn, a, b, r, o);
      if (sc) m_cc = {r == 64'd0, r[63], o};
      it.g = g; it.res = r; it.ovf = o; it.cc = m_cc;
      sb.push_back(it);
      m_rr       = !g;
      m_owner    = g;
      m_inflight = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever response the DUT presents against the scoreboard head.
  initial begin
    item_t it;
    logic [1:0] ev;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected no response", rsp_valid);
        end else begin
          it = sb[0];
          ev = 2'b00;
          ev[it.g] = 1'b1;
          check("rsp_valid", 64'(rsp_valid), 64'(ev));
          check("rsp_result", rsp_result, it.res);
          check("rsp_ovf", 64'(rsp_ovf), 64'(it.ovf));
          check("rsp_cc", 64'(cc), 64'(it.cc));
          if (rsp_valid[it.g] && rsp_ready[it.g]) void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic set_req(input logic r, input logic [1:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
    if (r) begin
      req1_fn = fn; req1_a = a; req1_b = b; req1_set_cc = sc;
    end else begin
      req0_fn = fn; req0_a = a; req0_b = b; req0_set_cc = sc;
    end
  endtask

  task automatic randomize_reqs();
    set_req(1'b0, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    set_req(1'b1, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [63:0] held;
    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    set_req(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    set_req(1'b1, 2'd0, 64'd0, 64'd0, 1'b0);
    m_inflight = 1'b0; m_owner = 1'b0; m_rr = 1'b0; m_cc = 3'b100;
    seen_ready = 2'b00;

    // Reset with both requesters valid
    cycle();
    cycle();
    check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("rst_cc", 64'(cc), 64'(3'b100));
    check("rst_result", rsp_result, 64'd0);
    reset = 1'b0;
    req_valid = 2'b00;

    // Single add
    set_req(1'b0, 2'd0, 64'd5, 64'd7, 1'b1);
    req_valid = 2'b01; rsp_ready = 2'b01;
    cycle();
    req_valid = 2'b00;
    check("add_valid", 64'(rsp_valid), 64'(2'b01));
    check("add_result", rsp_result, 64'd12);
    check("add_ovf", 64'(rsp_ovf), 64'd0);
    check("add_cc", 64'(cc), 64'(3'b000));
    cycle();

    // Sub to zero, then signed overflow
    set_req(1'b1, 2'd1, 64'd9, 64'd9, 1'b1);
    req_valid = 2'b10; rsp_ready = 2'b10;
    cycle();
    req_valid = 2'b00;
    check("sub_result", rsp_result, 64'd0);
    check("sub_cc", 64'(cc), 64'(3'b100));
    cycle();
    set_req(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    check("ovf_result", rsp_result, 64'h8000_0000_0000_0000);
    check("ovf_flag", 64'(rsp_ovf), 64'd1);
    check("ovf_cc", 64'(cc), 64'(3'b011));
    cycle();

    // Fairness: both valid, responses always consumed
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      randomize_reqs();
      cycle();
      check("fair_order", 64'(seen_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    req_valid = 2'b00;
    cycle();

    // Backpressure, including rsp_ready on the non-owning bit
    set_req(1'b0, 2'd0, 64'd1, 64'd1, 1'b1);
    req_valid = 2'b01; rsp_ready = 2'b00;
    cycle();
    held = rsp_result;
    check("bp_first", held, 64'd2);
    req_valid = 2'b11;
    randomize_reqs();
    for (int i = 0; i < 4; i++) begin
      rsp_ready = (i == 3) ? 2'b10 : 2'b00;
      cycle();
      check("bp_ready", 64'(seen_ready), 64'd0);
      check("bp_hold", rsp_result, held);
      check("bp_cc", 64'(cc), 64'(3'b000));
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    cycle();

    // set_cc=0 leaves cc alone; reset while holding a response
    set_req(1'b0, 2'd3, 64'hF0, 64'hF0, 1'b0);
    req_valid = 2'b01; rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b00;
    check("xor_result", rsp_result, 64'd0);
    check("xor_cc_kept", 64'(cc), 64'(3'b000));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_resp_valid", 64'(rsp_valid), 64'(2'b00));
    check("rst_resp_cc", 64'(cc), 64'(3'b100));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      reset = ($urandom_range(0, 199) == 0);
      randomize_reqs();
      cycle();
    end
    reset = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) cycle();
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(rsp_valid), 64'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
